// File: rtl/mem_access_unit.sv
// Load/store front end for one byte-lane block RAM port. It splits any access
// that straddles a 32-bit word into two in-word accesses, then merges and extends load data.
module mem_access_unit #(
    parameter int SCALE = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [31:0]      rsp_rdata,
    output logic             mem_oe,
    output logic [SCALE-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_we,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t           state, state_nxt;
    logic             we_q, signed_q, split_q;
    logic [1:0]       size_q;
    logic [SCALE-1:0] addr_q;
    logic [31:0]      wdata_q, lo_data;
    logic [2:0]       nbytes, n1, n2;
    logic [SCALE-3:0] word_nxt;
    logic             accept, is_err;
    logic             unused_addr_hi;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    size_bytes = 3'd1;
            2'd1:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] n);
        for (int i = 0; i < 4; i++) lane_mask[i] = (i < int'(n));
    endfunction

    function automatic logic [31:0] byte_mask(input logic [2:0] n);
        for (int i = 0; i < 4; i++) byte_mask[8*i +: 8] = (i < int'(n)) ? 8'hFF : 8'h00;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] nb,
                                           input logic sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = raw[7:0];
        h = raw[15:0];
        case (nb)
            3'd1:    extend = sgn ? 32'(b) : {24'd0, raw[7:0]};
            3'd2:    extend = sgn ? 32'(h) : {16'd0, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    assign accept         = req_valid && req_ready;
    assign nbytes         = size_bytes(size_q);
    assign n1             = split_q ? (3'd4 - {1'b0, addr_q[1:0]}) : nbytes;
    assign n2             = nbytes - n1;
    assign is_err         = (size_q == 2'd3);
    assign word_nxt       = addr_q[SCALE-1:2] + (SCALE-2)'(1);
    assign unused_addr_hi = ^req_addr[31:SCALE];

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Request and low-half capture registers carry no reset; only the FSM is reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr[SCALE-1:0];
            wdata_q  <= req_wdata;
            split_q  <= ({1'b0, req_addr[1:0]} + size_bytes(req_size)) > 3'd4;
        end
        if (state == HI) lo_data <= mem_rdata;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        mem_oe    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_we    = 4'd0;
        if (!rst) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) state_nxt = (req_size == 2'd3) ? RESP : LO;
                end
                LO: begin
                    mem_oe    = 1'b1;
                    mem_addr  = addr_q;
                    mem_we    = we_q ? lane_mask(n1) : 4'd0;
                    mem_wdata = wdata_q & byte_mask(n1);
                    state_nxt = split_q ? HI : RESP;
                end
                HI: begin
                    mem_oe    = 1'b1;
                    mem_addr  = {word_nxt, 2'b00};
                    mem_we    = we_q ? lane_mask(n2) : 4'd0;
                    mem_wdata = (wdata_q >> {n1, 3'b000}) & byte_mask(n2);
                    state_nxt = RESP;
                end
                RESP: begin
                    rsp_valid = 1'b1;
                    rsp_err   = is_err;
                    if (!we_q && !is_err) begin
                        if (split_q)
                            rsp_rdata = extend(((lo_data & byte_mask(n1)) |
                                                (mem_rdata << {n1, 3'b000})) & byte_mask(nbytes),
                                               nbytes, signed_q);
                        else
                            rsp_rdata = extend(mem_rdata & byte_mask(nbytes), nbytes, signed_q);
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-lane RAM model on the port side, and a byte-array
// reference memory that predicts bus accesses, latency and load results.
module tb_mem_access_unit;
    localparam int SCALE = 10;
    localparam int MEMSZ = 1 << SCALE;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_we, req_signed;
    logic [1:0]       req_size;
    logic [31:0]      req_addr, req_wdata;
    logic             rsp_valid, rsp_err;
    logic [31:0]      rsp_rdata;
    logic             mem_oe;
    logic [SCALE-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_we;
    logic [31:0]      mem_rdata = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram  [MEMSZ];
    logic [7:0] refm [MEMSZ];
    bit         ram_ready = 1'b0;

    mem_access_unit #(.SCALE(SCALE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_oe(mem_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // RAM port: enables and data are shifted up by the in-word offset; read data comes back shifted down.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < MEMSZ; i++) ram[i] <= init_byte(i);
            ram_ready <= 1'b1;
        end else if (mem_oe) begin
            int base, off;
            logic [31:0] word;
            base = int'(mem_addr) & ~3;
            off  = int'(mem_addr) & 3;
            for (int i = 0; i < 4; i++)
                if (mem_we[i] && (off + i) < 4) ram[base + off + i] <= mem_wdata[8*i +: 8];
            word = {ram[base + 3], ram[base + 2], ram[base + 1], ram[base]};
            mem_rdata <= word >> (8 * off);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input int n);
        return (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    endfunction

    function automatic logic [3:0] lanes(input int n);
        return 4'(((1 << n) - 1) & 15);
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] a, input logic [31:0] wd, input logic hold);
        int nb, off, n1, n2, nacc, exp_lat, lat, seen, a10;
        logic [31:0] ea [2];
        logic [3:0]  ewe [2];
        logic [31:0] ewd [2];
        logic [31:0] exp_rd, got_rd;
        logic        err, got_err;

        err  = (sz == 2'd3);
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a10  = int'(a[SCALE-1:0]);
        off  = a10 % 4;
        n1   = (nb < 4 - off) ? nb : 4 - off;
        n2   = nb - n1;
        nacc = err ? 0 : ((n2 > 0) ? 2 : 1);
        exp_lat = err ? 1 : nacc + 1;
        ea[0]  = 32'(a10);
        ewe[0] = we ? lanes(n1) : 4'd0;
        ewd[0] = wd & bmask(n1);
        ea[1]  = 32'((a10 - off + 4) % MEMSZ);
        ewe[1] = we ? lanes(n2) : 4'd0;
        ewd[1] = (wd >> (8 * n1)) & bmask(n2);

        exp_rd = 32'd0;
        if (!err && !we) begin
            for (int i = 0; i < nb; i++)
                exp_rd = exp_rd | (32'(refm[(a10 + i) % MEMSZ]) << (8 * i));
            if (sgn && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | ~bmask(nb);
        end
        if (!err && we)
            for (int i = 0; i < nb; i++) refm[(a10 + i) % MEMSZ] = wd[8*i +: 8];

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = a; req_wdata = wd;
        check_eq("idle_ready", 32'(req_ready), 32'd1);

        lat = 0; seen = 0; got_rd = 32'd0; got_err = 1'b0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = hold; req_we = 1'($urandom); req_size = 2'($urandom);
                req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            end
            check_eq("busy_ready", 32'(req_ready), 32'd0);
            if (mem_oe) begin
                if (seen < 2) begin
                    check_eq("acc_addr", 32'(mem_addr), ea[seen]);
                    check_eq("acc_we", 32'(mem_we), 32'(ewe[seen]));
                    if (we) check_eq("acc_wdata", mem_wdata, ewd[seen]);
                end
                seen++;
            end else begin
                check_eq("idle_bus", 32'(mem_addr) | 32'(mem_we) | mem_wdata, 32'd0);
            end
            if (rsp_valid) begin
                lat = k; got_rd = rsp_rdata; got_err = rsp_err;
            end else begin
                check_eq("rdata_idle", rsp_rdata, 32'd0);
            end
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("n_access", 32'(seen), 32'(nacc));
        check_eq("rsp_err", 32'(got_err), 32'(err));
        check_eq("rsp_rdata", got_rd, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < MEMSZ; i++) refm[i] = init_byte(i);
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_oe", 32'(mem_oe), 32'd0);
        check_eq("rst_rsp", 32'(rsp_valid) | 32'(rsp_err), 32'd0);
        check_eq("rst_bus", 32'(mem_addr) | 32'(mem_we) | mem_wdata | rsp_rdata, 32'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("post_rst_ready", 32'(req_ready), 32'd1);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 32'h05, 32'h1122_3344, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h05, 32'h0, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 32'h3FF, 32'h0000_ABCD, 1'b0);
        do_req(1'b0, 2'd1, 1'b1, 32'h3FF, 32'h0, 1'b0);
        do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 1'b1);
        do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_F7FE, 32'hCAFE_F00D, 1'b1);
        do_req(1'b0, 2'd2, 1'b1, 32'h3FE, 32'h0, 1'b1);
        req_valid = 1'b0;

        // Abandon a split load in its second access.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h05; req_wdata = 32'h0;
        check_eq("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("abort_lo_oe", 32'(mem_oe), 32'd1);
        @(negedge clk);
        check_eq("abort_hi_oe", 32'(mem_oe), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("abort_oe", 32'(mem_oe), 32'd0);
        check_eq("abort_bus", 32'(mem_addr) | 32'(mem_we) | mem_wdata, 32'd0);
        check_eq("abort_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_ready_after", 32'(req_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("abort_no_rsp", 32'(rsp_valid) | 32'(mem_oe), 32'd0);
        end

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[SCALE-1:2] = '1;
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                   1'($urandom));
        end
        req_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Requester-side controller for one port of the byte-lane dual-port block RAM. It accepts byte, halfword and word load/store requests at any byte address and drives the RAM port, splitting any access that crosses a 32-bit word boundary into two in-word accesses, because the RAM only supports accesses that stay within one word. It returns load data zero- or sign-extended, and reports completion for stores. It sits between the core's load/store stage and the RAM port.

## Interface

- SCALE, 10, RAM byte-address width (2**SCALE bytes); must be ≥3
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-low reset (0 = reset)
- req_valid  input  1  request present
- req_ready  output  1  unit can accept; handshake when req_valid && req_ready
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_signed  input  1  load sign-extend (ignored for stores and words)
- req_addr  input  32  byte address; bits above SCALE-1 ignored
- req_wdata  input  32  store data, low-justified
- rsp_valid  output  1  one-cycle completion pulse
- rsp_err  output  1  valid with rsp_valid; 1 = reserved size
- rsp_rdata  output  32  load result; 0 for stores, errors and whenever rsp_valid=0
- mem_oe  output  1  RAM port enable
- mem_addr  output  SCALE  RAM byte address
- mem_wdata  output  32  low-justified write data, unused lanes 0
- mem_we  output  4  low-justified byte enables (the RAM shifts them by mem_addr[1:0])
- mem_rdata  input  32  RAM read data, already right-shifted by offset; valid the cycle after mem_oe and held until the next mem_oe

## Operation

- Definitions: nbytes = 1, 2 or 4 from size. off = addr[1:0]. split = off + nbytes > 4. n1 = split ? 4-off : nbytes. n2 = nbytes - n1.
- States: IDLE, LO, HI, RESP.
- IDLE: req_ready=1. On handshake, latch we, size, signed, addr[SCALE-1:0], wdata and split. Go to RESP if size=3 (error), else go to LO.
- LO: mem_oe=1, mem_addr=addr, mem_we=(1<<n1)-1 for stores and 0 for loads, mem_wdata=wdata masked to n1 bytes. Go to HI if split, else to RESP.
- HI: capture mem_rdata into lo_data. mem_oe=1, mem_addr={word(addr)+1, 2'b00}, computed in SCALE bits so it wraps to 0 at the top of memory. mem_we=(1<<n2)-1 for stores. mem_wdata=(wdata>>8*n1) masked to n2 bytes. Go to RESP.
- RESP: rsp_valid=1. For loads, raw = split ? (lo_data masked to n1 bytes) | (mem_rdata<<8*n1) : mem_rdata. Mask raw to nbytes, then extend: sign-extend if signed and nbytes<4, else zero-extend. Stores return 0. Error returns rsp_err=1 with no memory access. Go to IDLE.
- The unit never drives a mem_we/offset pair that crosses a word: no 0011 at off 3, and no 1111 at off≠0.
- When mem_oe=0, mem_addr, mem_wdata and mem_we are 0.
- Addresses wrap modulo 2**SCALE.

## Timing

- Reset: in any cycle with rst=0, the next state is IDLE, and req_ready, rsp_valid, rsp_err, mem_oe and mem_we are forced to 0 combinationally. rsp_rdata, mem_addr and mem_wdata are 0.
- Reset mid-operation abandons the access. No rsp_valid is produced. A write already issued in LO stays committed.
- Latency from handshake cycle T: aligned access, mem_oe at T+1 and rsp_valid at T+2. Split access, mem_oe at T+1 and T+2, rsp_valid at T+3. Error, rsp_valid at T+1.
- req_ready=0 in LO, HI and RESP. The next handshake is possible no earlier than the cycle after RESP. Throughput is one request per 3 cycles (aligned) or 4 cycles (split).
- There is no rsp backpressure; the consumer must take rsp_valid when it pulses.
- req_* are sampled only at handshake and may change afterwards.

## Test plan

- Store word 0xDEADBEEF at 0x10, then load word at 0x10: one mem_oe each, mem_we=1111, rsp_rdata=0xDEADBEEF at T+2.
- With byte 0x80 at 0x13: signed byte load gives 0xFFFFFF80, unsigned gives 0x00000080; mem_addr=0x13, single access.
- Store word 0x11223344 at 0x05: (addr 0x05, we 0111, wdata 0x00223344), then (addr 0x08, we 0001, wdata 0x00000011). Load word at 0x05 gives 0x11223344 at T+3.
- SCALE=10, store half 0xABCD at 0x3FF: (0x3FF, 0001, 0xCD), then (0x000, 0001, 0xAB). Signed half load at 0x3FF gives 0xFFFFABCD.
- req_size=3: no mem_oe, rsp_valid and rsp_err at T+1, rsp_rdata=0. With req_valid held high back-to-back, req_ready is low in LO/HI/RESP.
- Drive rst=0 during HI of a split load: mem_oe=0 that cycle, no rsp_valid, req_ready=1 in the first cycle after rst returns to 1.
